l1_mem_arbiter: RTL and testbench
=================================

# l1_mem_arbiter

Shares the single 256-bit line port of the backing memory between the L1 instruction cache (line fills) and the L1 data cache (line fills and dirty write-backs). It sequences one line transaction at a time through a small FSM, arbitrates round-robin when both caches miss together, and aborts transactions that the memory never answers. It sits between the two L1 caches and the memory/L2 interface.

## Interface
- ADDR_W, 32, address width on all ports
- LINE_W, 256, cache line width in bits (8 words)
- TIMEOUT, 255, max cycles in BUS before abort (≥1)

- CLK  in  1  clock, all state on rising edge
- RESET_N  in  1  reset, asynchronous, active-low
- i_req  in  1  icache miss request, level, held until i_valid seen
- i_address  in  ADDR_W  icache miss address
- i_data  out  LINE_W  fill line returned to icache
- i_valid  out  1  one-cycle pulse: i_data valid, icache transaction done
- d_req  in  1  dcache request, level, held until d_valid seen
- d_we  in  1  1 = write-back of d_wdata, 0 = line fill
- d_address  in  ADDR_W  dcache address
- d_wdata  in  LINE_W  write-back line
- d_data  out  LINE_W  fill line returned to dcache
- d_valid  out  1  one-cycle pulse: dcache transaction done
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_address  out  ADDR_W  line-aligned memory address
- mem_wdata  out  LINE_W  write data
- mem_rdata  in  LINE_W  read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion pulse from memory
- busy  out  1  1 whenever FSM not in IDLE
- timeout_err  out  1  sticky, set on any timeout abort

## Operation
- FSM states: IDLE, BUS, DONE. All outputs registered.
- IDLE: if neither req, stay. If exactly one req, grant it. If both, grant requester opposite to last_grant; last_grant updated on every grant. last_grant resets to D, so icache wins the first tie.
- On grant (IDLE→BUS): latch owner, mem_address = {req address[ADDR_W-1:5], 5'b0} (low 5 bits forced zero), mem_we = d_we for dcache else 0, mem_wdata = d_wdata for dcache else 0; mem_req←1; timeout counter←0.
- BUS: mem_req held 1, address/we/wdata stable. Counter increments each cycle. Request inputs ignored.
- mem_ready in BUS: mem_req←0; for a read, owner's data register←mem_rdata; for a write, owner's data register unchanged; go DONE.
- Timeout: counter reaches TIMEOUT with mem_ready low → mem_req←0, owner's data register←0, timeout_err←1, go DONE. mem_ready and counter==TIMEOUT in same cycle: mem_ready wins, no error.
- DONE: owner's valid = 1 for exactly this cycle; next state IDLE unconditionally.
- mem_ready outside BUS ignored.
- i_data/d_data hold their last value until overwritten by their own next transaction.
- timeout_err cleared only by reset.
- Reset (any time, incl. mid-transaction): state IDLE, mem_req/mem_we/i_valid/d_valid/busy/timeout_err = 0, mem_address/mem_wdata/i_data/d_data = 0, counter = 0, last_grant = D. Aborted transaction is not resumed.

## Timing
- Cycle n: IDLE samples req. n+1: BUS, mem_req=1. Memory ready at cycle m (m≥n+1) → m+1: DONE, valid=1. m+2: IDLE.
- Minimum latency req-sample to valid: 2 cycles (mem_ready in first BUS cycle).
- Requester must deassert req by the edge after it samples valid; a req still high in IDLE at m+2 is a new request.
- Back-to-back: second requester waiting during a transaction is granted in the IDLE cycle at m+2; memory idle ≥2 cycles between transactions.
- Timeout abort: valid at cycle n+TIMEOUT+2 relative to grant sample at n.

## Test plan
- Single icache fill: i_req, i_address=0x0000_1234, mem_ready 3 cycles after mem_req, mem_rdata=pattern A -> mem_address=0x0000_1220, mem_we=0, i_valid one cycle with i_data=A, d_valid stays 0.
- Dcache write-back: d_req, d_we=1, d_address=0x8000_0040, d_wdata=B -> mem_we=1, mem_wdata=B, mem_address=0x8000_0040; d_valid pulse, d_data unchanged.
- Simultaneous i_req and d_req from reset, held -> icache served first, then dcache; repeated tie alternates I,D,I,D.
- Timeout with TIMEOUT=4, mem_ready never -> mem_req drops after 4 BUS cycles, valid pulses with data 0, timeout_err=1 and stays 1; mem_ready on the exact 4th cycle -> normal completion, timeout_err=0.
- RESET_N low mid-BUS -> all outputs zero immediately (asynchronously); after release with no req, busy=0, no valid pulse; late mem_ready ignored.
- Stray mem_ready in IDLE and DONE -> no state change, no data update.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between the L1 I and D caches.
// One line transaction at a time; unanswered transactions are aborted.
module l1_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_data,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_data,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t          state, state_nx;
  logic            owner_d, owner_d_nx;
  logic            last_d, last_d_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            mem_req_nx, mem_we_nx;
  logic [ADDR_W-1:0] mem_address_nx;
  logic [LINE_W-1:0] mem_wdata_nx;
  logic [LINE_W-1:0] i_data_nx, d_data_nx;
  logic            i_valid_nx, d_valid_nx;
  logic            busy_nx, terr_nx;
  logic            gnt_d;
  logic [ADDR_W-1:0] addr_sel;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      last_d      <= 1'b1;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_data      <= '0;
      d_data      <= '0;
      i_valid     <= 1'b0;
      d_valid     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      owner_d     <= owner_d_nx;
      last_d      <= last_d_nx;
      cnt         <= cnt_nx;
      mem_req     <= mem_req_nx;
      mem_we      <= mem_we_nx;
      mem_address <= mem_address_nx;
      mem_wdata   <= mem_wdata_nx;
      i_data      <= i_data_nx;
      d_data      <= d_data_nx;
      i_valid     <= i_valid_nx;
      d_valid     <= d_valid_nx;
      busy        <= busy_nx;
      timeout_err <= terr_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    owner_d_nx     = owner_d;
    last_d_nx      = last_d;
    cnt_nx         = cnt;
    mem_req_nx     = mem_req;
    mem_we_nx      = mem_we;
    mem_address_nx = mem_address;
    mem_wdata_nx   = mem_wdata;
    i_data_nx      = i_data;
    d_data_nx      = d_data;
    i_valid_nx     = 1'b0;
    d_valid_nx     = 1'b0;
    terr_nx        = timeout_err;
    // On a tie the dcache wins only if the icache was granted last
    gnt_d    = d_req & (~i_req | ~last_d);
    addr_sel = gnt_d ? d_address : i_address;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_nx       = BUS;
          owner_d_nx     = gnt_d;
          last_d_nx      = gnt_d;
          mem_address_nx = {addr_sel[ADDR_W-1:5], 5'b0};
          mem_we_nx      = gnt_d & d_we;
          mem_wdata_nx   = gnt_d ? d_wdata : '0;
          mem_req_nx     = 1'b1;
          cnt_nx         = '0;
        end
      end
      BUS: begin
        if (mem_ready) begin
          state_nx   = DONE;
          mem_req_nx = 1'b0;
          i_valid_nx = ~owner_d;
          d_valid_nx = owner_d;
          if (!mem_we) begin
            if (owner_d) d_data_nx = mem_rdata;
            else         i_data_nx = mem_rdata;
          end
        end else if (cnt == CW'(TIMEOUT)) begin
          state_nx   = DONE;
          mem_req_nx = 1'b0;
          terr_nx    = 1'b1;
          i_valid_nx = ~owner_d;
          d_valid_nx = owner_d;
          if (owner_d) d_data_nx = '0;
          else         i_data_nx = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter with TIMEOUT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_l1_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          i_req, d_req, d_we, mem_ready;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_data, d_data, mem_wdata;
  logic          i_valid, d_valid, mem_req, mem_we, busy, timeout_err;
  logic [AW-1:0] mem_address;

  int checks   = 0;
  int failures = 0;

  l1_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .i_req(i_req), .i_address(i_address),
    .i_data(i_data), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_address(d_address),
    .d_wdata(d_wdata), .d_data(d_data), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic respond(input int w, input logic [LW-1:0] dat);
    repeat (w) tick();
    mem_ready = 1'b1;
    mem_rdata = dat;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  logic [LW-1:0] pa, pb, pc, pe, pf;
  logic [LW-1:0] pt [4];
  logic [AW-1:0] exp_addr;

  initial begin
    pa = {8{32'hA5A5_0001}};
    pb = {8{32'hB0B0_0002}};
    pc = {8{32'hC3C3_0003}};
    pe = {8{32'hE1E1_0005}};
    pf = {8{32'hF0F0_0006}};
    for (int k = 0; k < 4; k++) pt[k] = {8{32'h1000_0000 + 32'(k)}};
    i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    RESET_N = 1'b1;
    tick();
    do_reset();

    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_mem_req", LW'(mem_req), LW'(0));
    chk("rst_addr", LW'(mem_address), LW'(0));
    chk("rst_terr", LW'(timeout_err), LW'(0));

    // single icache fill, mem_ready 3 cycles after mem_req
    i_req = 1; i_address = 32'h0000_1234;
    tick();
    chk("if_mem_req", LW'(mem_req), LW'(1));
    chk("if_addr", LW'(mem_address), LW'(32'h0000_1220));
    chk("if_we", LW'(mem_we), LW'(0));
    chk("if_busy", LW'(busy), LW'(1));
    respond(3, pa);
    chk("if_valid", LW'(i_valid), LW'(1));
    chk("if_data", i_data, pa);
    chk("if_dvalid", LW'(d_valid), LW'(0));
    chk("if_req_drop", LW'(mem_req), LW'(0));
    i_req = 0;
    tick();
    chk("if_valid_off", LW'(i_valid), LW'(0));
    chk("if_idle", LW'(busy), LW'(0));

    // dcache write-back
    d_req = 1; d_we = 1; d_address = 32'h8000_0040; d_wdata = pb;
    tick();
    chk("wb_we", LW'(mem_we), LW'(1));
    chk("wb_wdata", mem_wdata, pb);
    chk("wb_addr", LW'(mem_address), LW'(32'h8000_0040));
    respond(0, pc);
    chk("wb_dvalid", LW'(d_valid), LW'(1));
    chk("wb_ddata", d_data, LW'(0));
    chk("wb_ivalid", LW'(i_valid), LW'(0));
    d_req = 0; d_we = 0;
    tick();

    // ties from reset alternate I, D, I, D
    do_reset();
    i_req = 1; i_address = 32'h0000_0100;
    d_req = 1; d_address = 32'h0000_0200;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      chk($sformatf("tie%0d_addr", k), LW'(mem_address), LW'(exp_addr));
      respond(0, pt[k]);
      chk($sformatf("tie%0d_ivalid", k), LW'(i_valid), LW'(k % 2 == 0));
      chk($sformatf("tie%0d_dvalid", k), LW'(d_valid), LW'(k % 2 == 1));
      if (k % 2 == 0) chk($sformatf("tie%0d_data", k), i_data, pt[k]);
      else            chk($sformatf("tie%0d_data", k), d_data, pt[k]);
      if (k == 3) begin
        i_req = 0; d_req = 0;
      end
      tick();
      tick();
    end

    // timeout: mem_ready never comes
    i_req = 1; i_address = 32'h0000_0040;
    tick();
    repeat (4) tick();
    chk("to_req_held", LW'(mem_req), LW'(1));
    chk("to_terr_pre", LW'(timeout_err), LW'(0));
    tick();
    chk("to_valid", LW'(i_valid), LW'(1));
    chk("to_data", i_data, LW'(0));
    chk("to_terr", LW'(timeout_err), LW'(1));
    chk("to_req_drop", LW'(mem_req), LW'(0));
    i_req = 0;
    tick();
    chk("to_terr_sticky", LW'(timeout_err), LW'(1));
    chk("to_busy", LW'(busy), LW'(0));

    // mem_ready on the last allowed cycle completes normally
    do_reset();
    d_req = 1; d_we = 0; d_address = 32'h0000_0060;
    tick();
    respond(4, pe);
    chk("edge_dvalid", LW'(d_valid), LW'(1));
    chk("edge_data", d_data, pe);
    chk("edge_terr", LW'(timeout_err), LW'(0));
    d_req = 0;
    tick();

    // asynchronous reset mid-BUS, then late mem_ready
    i_req = 1; i_address = 32'h0000_0300;
    tick();
    chk("ar_pre_busy", LW'(busy), LW'(1));
    #1 RESET_N = 1'b0;
    #1;
    chk("ar_mem_req", LW'(mem_req), LW'(0));
    chk("ar_busy", LW'(busy), LW'(0));
    chk("ar_addr", LW'(mem_address), LW'(0));
    chk("ar_ddata", d_data, LW'(0));
    i_req = 0;
    tick();
    RESET_N = 1'b1;
    tick();
    mem_ready = 1; mem_rdata = pf;
    tick();
    mem_ready = 0;
    chk("ar_idle", LW'(busy), LW'(0));
    chk("ar_ivalid", LW'(i_valid), LW'(0));
    chk("ar_idata", i_data, LW'(0));

    // stray mem_ready in DONE is ignored
    i_req = 1; i_address = 32'h0000_0400;
    tick();
    respond(1, pa);
    chk("st_data", i_data, pa);
    i_req = 0;
    mem_ready = 1; mem_rdata = pf;
    tick();
    mem_ready = 0;
    chk("st_data_hold", i_data, pa);
    chk("st_busy", LW'(busy), LW'(0));
    chk("st_ivalid", LW'(i_valid), LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
